sram_responder: RTL

Synthesizable slave-side model of the processor's external 16-bit SRAM bus. It answers the CPU's active-low CE/UB/LB/OE/WE strobes, 20-bit ADDR and shared tri-state Data with configurable read latency and byte-lane writes. A side loader port preloads programs. A post-reset clear sweep zeroes the array before the bus is serviced.

---
 rtl/sram_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - slave-side model of a 16-bit strobed SRAM bus with side loader and clear sweep
module sram_responder #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CE,
  input  logic              UB,
  input  logic              LB,
  input  logic              OE,
  input  logic              WE,
  input  logic [19:0]       ADDR,
  inout  wire  [15:0]       Data,
  input  logic              LD_EN,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [15:0]       LD_DATA,
  output logic              Busy,
  output logic              Drop
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counter only ever holds READ_LATENCY-1 down to 0.
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RWAIT,
    ST_DRIVE
  } state_t;

  // With a single-cycle latency there is nothing to wait for.
  localparam state_t ST_START = (READ_LATENCY == 1) ? ST_DRIVE : ST_RWAIT;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] lat_addr;
  logic [ADDR_W-1:0] lat_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       rd_data;
  logic              drv_hi;
  logic              drv_lo;

  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wr;
  logic              bus_rd;
  logic              addr_chg;

  logic              mem_we_hi;
  logic              mem_we_lo;
  logic [ADDR_W-1:0] mem_wa;
  logic [15:0]       mem_wd;
  logic              drop_set;
  logic              drive_ok;

  // Upper address bits alias onto the implemented array.
  logic              unused_addr;
  assign unused_addr = ^ADDR[19:ADDR_W];

  assign bus_addr = ADDR[ADDR_W-1:0];
  assign bus_wr   = ~CE & ~WE;
  // WE low always means write, so a read needs WE high.
  assign bus_rd   = ~CE & ~OE & WE;
  assign addr_chg = (bus_addr != lat_addr);

  // State register: FSM state, sweep pointer, latched read address and latency counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_CLEAR;
      ptr      <= '0;
      lat_addr <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      lat_addr <= lat_nxt;
      cnt      <= cnt_nxt;
      if (state == ST_CLEAR) begin
        ptr <= ptr + ADDR_W'(1);
      end
    end
  end

  // Next-state logic: sweep, read start/restart, latency countdown and aborts.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_addr;
    cnt_nxt   = cnt;
    unique case (state)
      ST_CLEAR: begin
        // Pointer all ones means the last word is being cleared this cycle.
        if (&ptr) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus_rd) begin
          lat_nxt   = bus_addr;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_START;
        end
      end
      ST_RWAIT, ST_DRIVE: begin
        // Covers both a dropped request and a write, which is never a read.
        if (!bus_rd) begin
          state_nxt = ST_IDLE;
        end else if (addr_chg) begin
          lat_nxt   = bus_addr;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_START;
        end else if (state == ST_RWAIT) begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = ST_DRIVE;
          end
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Output decode: Busy, the single memory write port and the drive/drop conditions.
  always_comb begin
    Busy      = (state == ST_CLEAR);
    mem_we_hi = 1'b0;
    mem_we_lo = 1'b0;
    mem_wa    = bus_addr;
    mem_wd    = Data;
    drop_set  = 1'b0;
    drive_ok  = 1'b0;
    if (!Reset) begin
      if (state == ST_CLEAR) begin
        mem_we_hi = 1'b1;
        mem_we_lo = 1'b1;
        mem_wa    = ptr;
        mem_wd    = 16'h0000;
      end else if (LD_EN) begin
        // Loader owns the write port; any concurrent bus write is lost.
        mem_we_hi = 1'b1;
        mem_we_lo = 1'b1;
        mem_wa    = LD_ADDR;
        mem_wd    = LD_DATA;
        drop_set  = bus_wr;
      end else if (bus_wr) begin
        mem_we_hi = ~UB;
        mem_we_lo = ~LB;
      end
      drive_ok = (state == ST_DRIVE) && bus_rd && !addr_chg;
    end
  end

  // Registered lane drive enables and the collision pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      drv_hi <= 1'b0;
      drv_lo <= 1'b0;
      Drop   <= 1'b0;
    end else begin
      drv_hi <= drive_ok & ~UB;
      drv_lo <= drive_ok & ~LB;
      Drop   <= drop_set;
    end
  end

  // Storage array with byte-lane writes; the read register tracks the latched word every cycle.
  always_ff @(posedge Clk) begin
    if (mem_we_hi) begin
      mem[mem_wa][15:8] <= mem_wd[15:8];
    end
    if (mem_we_lo) begin
      mem[mem_wa][7:0] <= mem_wd[7:0];
    end
    rd_data <= mem[lat_addr];
  end

  assign Data[15:8] = drv_hi ? rd_data[15:8] : 8'hzz;
  assign Data[7:0]  = drv_lo ? rd_data[7:0]  : 8'hzz;

endmodule
